// File: rtl/tx_pkg.sv
// Shared state and receiver-mode encodings for the serial transmitter and its shift_reg4 receiver.
package tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Mode codes understood by shift_reg4
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_ROTL = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } tx_state_t;

endpackage

// File: rtl/tx_bit_counter.sv
// Bit position counter for one frame: clear wins over enable, o_last flags position WIDTH-1.
// Single-cycle update, no backpressure of its own; the caller gates i_en.
module tx_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_last = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out transmitter feeding shift_reg4 SI; WIDTH shift cycles after acceptance, then a done pulse.
// pause is registered: it turns the following SHIFT cycle into a hold cycle (M=00, bit held); start ignored unless ready.
module serial_tx_piso
    import tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic [WIDTH-1:0] D,
    output logic             ready,
    output logic             SO,
    output logic [1:0]       M,
    output logic             busy,
    output logic             done
);

    localparam int OUT_IDX = LSB_FIRST ? 0 : WIDTH - 1;

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_shadow;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;
    logic             w_accept;
    logic             w_shift;
    logic             w_last;
    logic             w_last_shift;

    // A shift edge happens only when the receiver was told to shift in this cycle,
    // so transmitter and receiver always move together.
    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_shift      = (r_state == S_SHIFT) && (r_mode == MODE_SHR);
    assign w_last_shift = w_shift && w_last;

    tx_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_en   (w_shift && !w_last),
        .o_last (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = MODE_HOLD;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                    w_mode_nxt  = MODE_SHR;
                end
            end
            S_SHIFT: begin
                if (w_last_shift) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_mode_nxt = pause ? MODE_HOLD : MODE_SHR;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mode   <= MODE_HOLD;
            r_shadow <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            if (w_accept) begin
                r_shadow <= D;
            end else if (w_shift) begin
                if (LSB_FIRST) begin
                    r_shadow <= r_shadow >> 1;
                end else begin
                    r_shadow <= r_shadow << 1;
                end
            end
        end
    end

    assign ready = (r_state == S_IDLE);
    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);
    assign M     = r_mode;
    assign SO    = (r_state == S_SHIFT) && r_shadow[OUT_IDX];

endmodule

// File: tb/tb_serial_tx_piso.sv
// Bench for serial_tx_piso: LSB-first and MSB-first instances share stimulus; a shift_reg4 model listens to the LSB-first one.
module tb_serial_tx_piso;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic [3:0] D;

    logic       ready_l, so_l, busy_l, done_l;
    logic [1:0] m_l;
    logic       ready_m, so_m, busy_m, done_m;
    logic [1:0] m_m;

    logic [3:0] rx_q = 4'b0000;
    logic       q_exp[$];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         lsb;
        logic [3:0] d;
        logic [3:0] seq;          // expected SO bits in send order, seq[3] first
        int         pause_after;  // raise pause after this many shift cycles (0 = none)
        int         pause_len;
        int         poke_at;      // drive start with 4'b1111 in this shift cycle (0 = none)
        int         exp_done;     // cycle of done, counted from the accepting edge
        bit         chk_q;
        logic [3:0] exp_q;
    } vec_t;

    always #5 clk = ~clk;

    serial_tx_piso #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .D(D),
        .ready(ready_l), .SO(so_l), .M(m_l), .busy(busy_l), .done(done_l)
    );

    serial_tx_piso #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .D(D),
        .ready(ready_m), .SO(so_m), .M(m_m), .busy(busy_m), .done(done_m)
    );

    // shift_reg4 receiver: shift right, SI enters the MSB
    always @(posedge clk) begin
        if (m_l == 2'b11) rx_q <= {so_l, rx_q[3:1]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v);
        int         shifts = 0;
        int         t = 0;
        int         done_t = -1;
        int         pause_left = 0;
        logic       so, rdy, bsy, dn;
        logic [1:0] m;
        q_exp.delete();
        for (int i = 3; i >= 0; i--) q_exp.push_back(v.seq[i]);
        start = 1'b1;
        D     = v.d;
        tick();
        start = 1'b0;
        D     = 4'($urandom);
        while (done_t < 0 && t < 20) begin
            t++;
            so  = v.lsb ? so_l    : so_m;
            rdy = v.lsb ? ready_l : ready_m;
            bsy = v.lsb ? busy_l  : busy_m;
            dn  = v.lsb ? done_l  : done_m;
            m   = v.lsb ? m_l     : m_m;
            if (m == 2'b11) begin
                shifts++;
                if (q_exp.size() == 0) chk("extra_shift", 32'(shifts), 32'd4);
                else chk("so_bit", 32'(so), 32'(q_exp.pop_front()));
            end else if (bsy && !dn && q_exp.size() != 0) begin
                chk("so_hold", 32'(so), 32'(q_exp[0]));
            end
            if (dn) begin
                done_t = t;
                chk("done_outputs", {29'd0, m, so}, 32'd0);
                if (v.chk_q) chk("rx_q_at_done", 32'(rx_q), 32'(v.exp_q));
            end else begin
                chk("busy_not_ready", {30'd0, bsy, rdy}, 32'b10);
            end
            if (m == 2'b11 && shifts == v.pause_after && v.pause_len > 0) pause_left = v.pause_len;
            if (pause_left > 0) begin
                pause = 1'b1;
                pause_left--;
            end else begin
                pause = 1'b0;
            end
            start = (m == 2'b11 && shifts == v.poke_at);
            D     = start ? 4'b1111 : 4'($urandom);
            if (done_t < 0) tick();
        end
        pause = 1'b0;
        start = 1'b0;
        chk("done_cycle", 32'(done_t), 32'(v.exp_done));
        chk("shift_count", 32'(shifts), 32'd4);
        chk("queue_empty", 32'(q_exp.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (v.lsb) chk("idle_after", {26'd0, ready_l, busy_l, done_l, m_l, so_l}, 32'b100000);
            else       chk("idle_after", {26'd0, ready_m, busy_m, done_m, m_m, so_m}, 32'b100000);
        end
        if (v.chk_q) chk("rx_q", 32'(rx_q), 32'(v.exp_q));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        vec_t after_abort;
        int   t_since;

        tbl[0] = '{lsb:1'b1, d:4'b1101, seq:4'b1011, pause_after:0, pause_len:0, poke_at:0, exp_done:5, chk_q:1'b1, exp_q:4'b1101};
        tbl[1] = '{lsb:1'b0, d:4'b1011, seq:4'b1011, pause_after:0, pause_len:0, poke_at:0, exp_done:5, chk_q:1'b0, exp_q:4'b0000};
        tbl[2] = '{lsb:1'b1, d:4'b0110, seq:4'b0110, pause_after:2, pause_len:2, poke_at:0, exp_done:7, chk_q:1'b1, exp_q:4'b0110};
        tbl[3] = '{lsb:1'b1, d:4'b0001, seq:4'b1000, pause_after:0, pause_len:0, poke_at:2, exp_done:5, chk_q:1'b1, exp_q:4'b0001};
        tbl[4] = '{lsb:1'b0, d:4'b0110, seq:4'b0110, pause_after:3, pause_len:1, poke_at:0, exp_done:6, chk_q:1'b0, exp_q:4'b0000};
        after_abort = '{lsb:1'b1, d:4'b0011, seq:4'b1100, pause_after:0, pause_len:0, poke_at:0, exp_done:5, chk_q:1'b1, exp_q:4'b0011};

        rst = 1'b1; start = 1'b0; pause = 1'b1; D = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        pause = 1'b0;
        tick();
        chk("reset_lsb", {26'd0, ready_l, busy_l, done_l, m_l, so_l}, 32'b100000);
        chk("reset_msb", {26'd0, ready_m, busy_m, done_m, m_m, so_m}, 32'b100000);

        for (int i = 0; i < 5; i++) run_frame(tbl[i]);

        // Reset in the third shift cycle aborts the frame without a done pulse
        start = 1'b1; D = 4'b1010;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort_third_shift", {30'd0, m_l}, 32'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_reset", {26'd0, ready_l, busy_l, done_l, m_l, so_l}, 32'b100000);
        tick();
        chk("abort_no_done", {26'd0, ready_l, busy_l, done_l, m_l, so_l}, 32'b100000);
        run_frame(after_abort);

        // start held high: a frame every 6 cycles
        q_exp.delete();
        start = 1'b1; D = 4'b1001;
        for (int i = 3; i >= 0; i--) q_exp.push_back(D[i] ? 1'b0 : 1'b0);
        q_exp.delete();
        q_exp.push_back(1'b1); q_exp.push_back(1'b0); q_exp.push_back(1'b0); q_exp.push_back(1'b1);
        t_since = 0;
        for (int t = 1; t <= 18; t++) begin
            tick();
            chk("b2b_ready", 32'(ready_l), 32'(t % 6 == 0));
            chk("b2b_done", 32'(done_l), 32'(t % 6 == 5));
            chk("b2b_busy", 32'(busy_l), 32'(t % 6 != 0));
            if (m_l == 2'b11) begin
                if (q_exp.size() == 0) chk("b2b_extra_shift", 32'(t), 32'd0);
                else chk("b2b_so", 32'(so_l), 32'(q_exp.pop_front()));
            end
            if (t == 18) begin
                start = 1'b0;
            end else if (ready_l) begin
                q_exp.push_back(1'b1); q_exp.push_back(1'b0); q_exp.push_back(1'b0); q_exp.push_back(1'b1);
            end
        end
        chk("b2b_queue_empty", 32'(q_exp.size()), 32'd0);
        chk("b2b_rx_q", 32'(rx_q), 32'b1001);
        tick();
        chk("b2b_stopped", {26'd0, ready_l, busy_l, done_l, m_l, so_l}, 32'b100000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
